register_rollback_sequencer: RTL

- Downstream consumer of the register snapshot block.
- Tracks which architectural registers the pipeline writes after a snapshot is taken.
- On a branch misprediction, it stalls the pipeline and writes back only those dirty registers, one per cycle, through the register file's write port.
- On correct resolution, it discards the checkpoint without any writes.

---
 rtl/register_rollback_sequencer_pkg.sv | 22 ++
 rtl/register_rollback_sequencer_lowest_set_index.sv | 24 ++
 rtl/register_rollback_sequencer.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/register_rollback_sequencer_pkg.sv
// Shared types and constants for the register rollback sequencer.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

package register_rollback_sequencer_pkg;

  localparam int REG_ADDR_WIDTH = 5;

  typedef logic [REG_ADDR_WIDTH-1:0] reg_addr_t;

  // r0 is hardwired to zero and is never tracked as dirty.
  localparam reg_addr_t REG_ZERO = '0;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    RESTORE,
    DONE
  } rollback_state_t;

endpackage

// File: rtl/register_rollback_sequencer_lowest_set_index.sv
// Priority encoder: reports the lowest set bit of a mask and whether any bit is set.
module lowest_set_index #(
  parameter int WIDTH = 32,
  parameter int IDX_W = 5
) (
  input  logic [WIDTH-1:0] mask,
  output logic [IDX_W-1:0] index,
  output logic             any_set
);

  // Scan from the top down so the lowest set bit is the last one assigned.
  always_comb begin
    // NOTE: defaults first so every path assigns every output; otherwise a latch is inferred.
    index   = '0;
    any_set = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (mask[i]) begin
        index   = IDX_W'(i);
        any_set = 1'b1;
      end
    end
  end

endmodule

// File: rtl/register_rollback_sequencer.sv
// Rollback sequencer: tracks registers written after a snapshot and, on a
// misprediction, writes the snapshot values of just those registers back to
// the register file, one per cycle, lowest index first.
module register_rollback_sequencer
  import register_rollback_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH = `DATA_WIDTH,
  parameter int NUM_REGS   = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 snapshot_taken,
  input  logic [NUM_REGS-1:0][DATA_WIDTH-1:0]  regs_snapshot,
  input  logic                                 wb_valid,
  input  logic [ADDR_WIDTH-1:0]                wb_addr,
  input  logic                                 restore_req,
  input  logic                                 resolve_ok,
  output logic                                 rf_we,
  output logic [ADDR_WIDTH-1:0]                rf_waddr,
  output logic [DATA_WIDTH-1:0]                rf_wdata,
  output logic                                 stall_pipeline,
  output logic                                 restore_done,
  output logic                                 restore_err,
  output logic                                 busy
);

  rollback_state_t       state;
  logic [NUM_REGS-1:0]   dirty;
  logic [NUM_REGS-1:0]   wb_bit;
  logic [NUM_REGS-1:0]   tracked;
  logic [NUM_REGS-1:0]   restore_mask;
  logic [NUM_REGS-1:0]   remaining;
  logic [ADDR_WIDTH-1:0] next_idx;
  logic [ADDR_WIDTH-1:0] unused_rest_idx;
  logic                  next_any;
  logic                  rest_any;
  logic                  more_pending;

  // One-hot of this cycle's writeback destination; r0 writes are never tracked.
  always_comb begin
    wb_bit = '0;
    if (wb_valid && (wb_addr != ADDR_WIDTH'(REG_ZERO))) begin
      wb_bit[wb_addr] = 1'b1;
    end
  end

  // A snapshot in the same cycle as a writeback keeps only that post-snapshot write.
  assign tracked = snapshot_taken ? wb_bit : (dirty | wb_bit);

  // When a restore is accepted, the same-cycle writeback joins the rollback set.
  assign restore_mask = (state == ARMED) ? (dirty | wb_bit) : dirty;

  // Mask left over once the selected register has been written.
  always_comb begin
    remaining           = restore_mask;
    remaining[next_idx] = 1'b0;
  end

  // Next register to restore.
  lowest_set_index #(
    .WIDTH (NUM_REGS),
    .IDX_W (ADDR_WIDTH)
  ) u_next_dirty (
    .mask    (restore_mask),
    .index   (next_idx),
    .any_set (next_any)
  );

  // Whether the write being issued is the last one.
  lowest_set_index #(
    .WIDTH (NUM_REGS),
    .IDX_W (ADDR_WIDTH)
  ) u_last_write (
    .mask    (remaining),
    .index   (unused_rest_idx),
    .any_set (rest_any)
  );

  assign stall_pipeline = ((state == ARMED) && restore_req) ||
                          (state == RESTORE) || (state == DONE);
  assign busy           = (state == RESTORE) || (state == DONE);

  // Checkpoint FSM with dirty tracking and registered rollback outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the dirty mask is real control state, so it is reset along with the FSM.
      state        <= IDLE;
      dirty        <= '0;
      more_pending <= 1'b0;
      rf_we        <= 1'b0;
      rf_waddr     <= '0;
      rf_wdata     <= '0;
      restore_done <= 1'b0;
      restore_err  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      rf_we        <= 1'b0;
      restore_done <= 1'b0;
      restore_err  <= 1'b0;
      unique case (state)
        IDLE: begin
          dirty       <= tracked;
          restore_err <= restore_req;
          if (snapshot_taken) begin
            state <= ARMED;
          end
        end
        ARMED: begin
          if (restore_req) begin
            if (next_any) begin
              rf_we        <= 1'b1;
              rf_waddr     <= next_idx;
              rf_wdata     <= regs_snapshot[next_idx];
              dirty        <= remaining;
              more_pending <= rest_any;
              state        <= RESTORE;
            end else begin
              restore_done <= 1'b1;
              state        <= DONE;
            end
          end else begin
            dirty <= tracked;
            if (!snapshot_taken && resolve_ok) begin
              state <= IDLE;
            end
          end
        end
        RESTORE: begin
          if (more_pending) begin
            rf_we        <= 1'b1;
            rf_waddr     <= next_idx;
            rf_wdata     <= regs_snapshot[next_idx];
            dirty        <= remaining;
            more_pending <= rest_any;
          end else begin
            restore_done <= 1'b1;
            state        <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
